// File: rtl/preg_freelist_pkg.sv
// Shared definitions for the physical register free list.
// Provides default width macros (FETCH_WIDTH, COMMIT_WIDTH, PREG_WIDTH) when
// the surrounding build has not set them. Also provides the free-list geometry,
// the pointer type (wrap bit plus index), the FSM state enum and the modular
// pointer helpers.
// The list depth (96 by default) need not be a power of two, so pointer
// arithmetic wraps explicitly at FL_SIZE and toggles the wrap bit.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif
`ifndef PREG_WIDTH
`define PREG_WIDTH 7
`endif

package preg_freelist_pkg;
  localparam int PREG_SIZE = 128;
  localparam int ARCH_REG  = 32;
  localparam int FL_SIZE   = PREG_SIZE - ARCH_REG;
  localparam int FL_IDX_W  = $clog2(FL_SIZE);
  localparam int FL_CNT_W  = FL_IDX_W + 1;
  localparam int PREG_W    = `PREG_WIDTH;

  typedef struct packed {
    logic                wrap;
    logic [FL_IDX_W-1:0] idx;
  } fl_ptr_t;

  // Offsets and counts share the pointer's total width.
  typedef logic [FL_IDX_W:0] fl_ofs_t;

  typedef enum logic {FL_NORMAL = 1'b0, FL_WALK = 1'b1} fl_state_e;

  // Advance a pointer by n (n < FL_SIZE).
  function automatic fl_ptr_t ptr_add(fl_ptr_t p, fl_ofs_t n);
    fl_ptr_t r;
    fl_ofs_t s;
    r = p;
    s = fl_ofs_t'(p.idx) + n;
    if (s >= fl_ofs_t'(FL_SIZE)) begin
      r.idx  = FL_IDX_W'(s - fl_ofs_t'(FL_SIZE));
      r.wrap = ~p.wrap;
    end else begin
      r.idx = FL_IDX_W'(s);
    end
    return r;
  endfunction

  // Move a pointer back by n (n < FL_SIZE).
  function automatic fl_ptr_t ptr_sub(fl_ptr_t p, fl_ofs_t n);
    fl_ptr_t r;
    r = p;
    if (fl_ofs_t'(p.idx) >= n) begin
      r.idx = FL_IDX_W'(fl_ofs_t'(p.idx) - n);
    end else begin
      r.idx  = FL_IDX_W'(fl_ofs_t'(p.idx) + fl_ofs_t'(FL_SIZE) - n);
      r.wrap = ~p.wrap;
    end
    return r;
  endfunction

  // Entries between head and tail. Equal wrap bits mean tail is not behind head.
  function automatic fl_ofs_t ptr_count(fl_ptr_t t, fl_ptr_t h);
    if (t.wrap == h.wrap) return fl_ofs_t'(t.idx) - fl_ofs_t'(h.idx);
    else return fl_ofs_t'(FL_SIZE) + fl_ofs_t'(t.idx) - fl_ofs_t'(h.idx);
  endfunction
endpackage

// File: rtl/preg_freelist_prefix_count.sv
// freelist_prefix_count: per-lane exclusive prefix popcount of a request vector.
// Ports:
//   vec_i    : lane request bits
//   prefix_o : prefix_o[i] = number of set bits in vec_i[i-1:0]
//   total_o  : number of set bits in vec_i
module freelist_prefix_count #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         vec_i,
  output logic [N-1:0][CW-1:0] prefix_o,
  output logic [CW-1:0]        total_o
);
  always_comb begin
    logic [CW-1:0] acc;
    acc      = '0;
    prefix_o = '0;
    for (int i = 0; i < N; i++) begin
      prefix_o[i] = acc;
      acc         = acc + CW'(vec_i[i]);
    end
    total_o = acc;
  end
endmodule

// File: rtl/preg_freelist.sv
// preg_freelist: circular free list of physical registers feeding rename.
// Grants up to ALLOC_NUM pregs per cycle (all-or-nothing) and reclaims up to
// FREE_NUM pregs per cycle at commit. On a redirect it enters WALK. In WALK
// the head rolls back one entry per squashed allocation. The RAM is never
// rewritten by a walk, so the same pregs are handed out again afterwards.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   alloc_en_i      : lanes requesting a new rd
//   alloc_ready_o   : allocation accepted this cycle (combinational)
//   alloc_preg_o    : preg per lane, valid when alloc_en_i[i] & alloc_ready_o
//   free_en_i       : commit lanes releasing an old preg
//   free_preg_i     : released preg per lane
//   redirect_i      : backend flush, enters WALK
//   walk_en_i       : walk lanes squashing an allocating instruction
//   walk_done_i     : last walk beat, returns to NORMAL next cycle
//   free_cnt_o      : number of free entries
//   dbg_state_o     : FSM state
// Option PREG_FREELIST_PERF_EN adds perf_stall_cnt_o (saturating stall
// cycles) and perf_min_free_o (low-water mark of free_cnt_o).
// Valid/ready: a request is taken exactly in cycles where alloc_ready_o is
// high and alloc_en_i is nonzero. alloc_ready_o never depends on alloc_en_i.
// Frees are always accepted and have no ready.
module preg_freelist
  import preg_freelist_pkg::*;
#(
  parameter int ALLOC_NUM = `FETCH_WIDTH,
  parameter int FREE_NUM  = `COMMIT_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ALLOC_NUM-1:0]              alloc_en_i,
  output logic                              alloc_ready_o,
  output logic [ALLOC_NUM-1:0][PREG_W-1:0]  alloc_preg_o,
  input  logic [FREE_NUM-1:0]               free_en_i,
  input  logic [FREE_NUM-1:0][PREG_W-1:0]   free_preg_i,
  input  logic                              redirect_i,
  input  logic [FREE_NUM-1:0]               walk_en_i,
  input  logic                              walk_done_i,
  output logic [FL_CNT_W-1:0]               free_cnt_o,
  output fl_state_e                         dbg_state_o
`ifdef PREG_FREELIST_PERF_EN
  ,
  output logic [31:0]                       perf_stall_cnt_o,
  output logic [FL_CNT_W-1:0]               perf_min_free_o
`endif
);
  localparam int AW = $clog2(ALLOC_NUM + 1);
  localparam int FW = $clog2(FREE_NUM + 1);

  logic [PREG_W-1:0] entry_q [FL_SIZE];
  fl_ptr_t           head_q, head_d, tail_q, tail_d;
  fl_state_e         state_q, state_d;

  logic [ALLOC_NUM-1:0][AW-1:0] a_pre;
  logic [AW-1:0]                a_tot;
  logic [FREE_NUM-1:0][FW-1:0]  f_pre;
  logic [FW-1:0]                f_tot;
  logic [FREE_NUM-1:0][FW-1:0]  w_pre;
  logic [FW-1:0]                w_tot;

  logic [FL_CNT_W-1:0]               count;
  logic                              alloc_fire;
  logic                              walking;
  logic [FREE_NUM-1:0][FL_IDX_W-1:0] wr_idx;

  freelist_prefix_count #(.N(ALLOC_NUM), .CW(AW)) u_alloc_pc (
    .vec_i(alloc_en_i), .prefix_o(a_pre), .total_o(a_tot));
  freelist_prefix_count #(.N(FREE_NUM), .CW(FW)) u_free_pc (
    .vec_i(free_en_i), .prefix_o(f_pre), .total_o(f_tot));
  freelist_prefix_count #(.N(FREE_NUM), .CW(FW)) u_walk_pc (
    .vec_i(walk_en_i), .prefix_o(w_pre), .total_o(w_tot));

  always_comb begin
    fl_ptr_t rp;
    count   = ptr_count(tail_q, head_q);
    walking = (state_q == FL_WALK);
    // Ready is conservative: it needs a full ALLOC_NUM entries whatever the lane mask.
    alloc_ready_o = ~rst & ~walking & ~redirect_i &
                    (count >= FL_CNT_W'(ALLOC_NUM));
    alloc_fire    = alloc_ready_o & (|alloc_en_i);
    alloc_preg_o  = '0;
    for (int i = 0; i < ALLOC_NUM; i++) begin
      rp = ptr_add(head_q, fl_ofs_t'(a_pre[i]));
      alloc_preg_o[i] = entry_q[rp.idx];
    end
    wr_idx = '0;
    for (int i = 0; i < FREE_NUM; i++) begin
      rp = ptr_add(tail_q, fl_ofs_t'(f_pre[i]));
      wr_idx[i] = rp.idx;
    end
    head_d = head_q;
    if (alloc_fire) head_d = ptr_add(head_q, fl_ofs_t'(a_tot));
    else if (walking) head_d = ptr_sub(head_q, fl_ofs_t'(w_tot));
    tail_d = ptr_add(tail_q, fl_ofs_t'(f_tot));
    state_d = state_q;
    case (state_q)
      FL_NORMAL: if (redirect_i) state_d = FL_WALK;
      FL_WALK:   if (walk_done_i && !redirect_i) state_d = FL_NORMAL;
      default:   state_d = FL_NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '{wrap: 1'b1, idx: '0};
      state_q <= FL_NORMAL;
      for (int i = 0; i < FL_SIZE; i++) entry_q[i] <= PREG_W'(ARCH_REG + i);
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      state_q <= state_d;
      for (int i = 0; i < FREE_NUM; i++)
        if (free_en_i[i]) entry_q[wr_idx[i]] <= free_preg_i[i];
    end
  end

  assign free_cnt_o  = count;
  assign dbg_state_o = state_q;

  // Next occupancy without modular wrap, so overflow stays visible.
  logic [FL_CNT_W+1:0] cnt_next_wide;
  logic [FL_CNT_W+1:0] cnt_walk_wide;
  always_comb begin
    cnt_walk_wide = (FL_CNT_W+2)'(count) + (walking ? (FL_CNT_W+2)'(w_tot) : '0);
    cnt_next_wide = cnt_walk_wide + (FL_CNT_W+2)'(f_tot) -
                    (alloc_fire ? (FL_CNT_W+2)'(a_tot) : '0);
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    cnt_next_wide <= (FL_CNT_W+2)'(FL_SIZE));
  a_walk_bound: assert property (@(posedge clk) disable iff (rst)
    walking |-> (cnt_walk_wide <= (FL_CNT_W+2)'(FL_SIZE)));

`ifdef PREG_FREELIST_PERF_EN
  logic [31:0]         stall_q;
  logic [FL_CNT_W-1:0] min_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      min_q   <= FL_CNT_W'(FL_SIZE);
    end else begin
      if ((|alloc_en_i) && !alloc_ready_o && !walking && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
      if (count < min_q) min_q <= count;
    end
  end
  assign perf_stall_cnt_o = stall_q;
  assign perf_min_free_o  = min_q;
`endif
endmodule

// File: tb/tb_preg_freelist.sv
// Self-checking bench for preg_freelist. The reference model is a queue of
// free pregs in grant order. It also keeps a stack of recent grants, which a
// walk returns to the front of the queue.
module tb_preg_freelist;
  import preg_freelist_pkg::*;

  localparam int AN = `FETCH_WIDTH;
  localparam int FN = `COMMIT_WIDTH;
  localparam int PW = `PREG_WIDTH;

  logic clk = 1'b0;
  logic rst;
  logic [AN-1:0]         alloc_en;
  logic                  alloc_ready;
  logic [AN-1:0][PW-1:0] alloc_preg;
  logic [FN-1:0]         free_en;
  logic [FN-1:0][PW-1:0] free_preg;
  logic                  redirect;
  logic [FN-1:0]         walk_en;
  logic                  walk_done;
  logic [FL_CNT_W-1:0]   free_cnt;
  fl_state_e             dbg_state;
`ifdef PREG_FREELIST_PERF_EN
  logic [31:0]           perf_stall;
  logic [FL_CNT_W-1:0]   perf_min;
`endif

  preg_freelist dut (
    .clk(clk), .rst(rst),
    .alloc_en_i(alloc_en), .alloc_ready_o(alloc_ready), .alloc_preg_o(alloc_preg),
    .free_en_i(free_en), .free_preg_i(free_preg),
    .redirect_i(redirect), .walk_en_i(walk_en), .walk_done_i(walk_done),
    .free_cnt_o(free_cnt), .dbg_state_o(dbg_state)
`ifdef PREG_FREELIST_PERF_EN
    , .perf_stall_cnt_o(perf_stall), .perf_min_free_o(perf_min)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state.
  logic [PW-1:0] m_fl[$];
  logic [PW-1:0] m_hist[$];
  logic [PW-1:0] exp_q[$];   // granted and not yet freed
  bit            m_walk;
  int            m_stall;
  int            m_min;
  logic                  exp_ready;
  logic [FL_CNT_W-1:0]   exp_cnt;
  logic [AN-1:0][PW-1:0] exp_preg, exp_mask, e_vec;

  task automatic set_idle();
    alloc_en = '0; free_en = '0; free_preg = '0;
    redirect = 1'b0; walk_en = '0; walk_done = 1'b0;
  endtask

  task automatic m_reset();
    m_fl.delete(); m_hist.delete(); exp_q.delete();
    for (int i = 0; i < FL_SIZE; i++) m_fl.push_back(PW'(ARCH_REG + i));
    m_walk = 0; m_stall = 0; m_min = FL_SIZE;
  endtask

  task automatic do_reset();
    rst = 1'b1; set_idle(); m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic void m_expect();
    int k;
    k = 0;
    exp_cnt   = FL_CNT_W'(m_fl.size());
    exp_ready = !m_walk && !redirect && (m_fl.size() >= AN);
    exp_preg  = '0;
    exp_mask  = '0;
    for (int i = 0; i < AN; i++) if (alloc_en[i]) begin
      if (exp_ready) begin exp_preg[i] = m_fl[k]; exp_mask[i] = '1; end
      k++;
    end
  endfunction

  // Apply one cycle of the current inputs to the model, then step to posedge+1.
  task automatic m_commit();
    logic [PW-1:0] p;
    if (m_fl.size() < m_min) m_min = m_fl.size();
    if ((|alloc_en) && !exp_ready && !m_walk) m_stall++;
    if (exp_ready) for (int i = 0; i < AN; i++) if (alloc_en[i]) begin
      p = m_fl.pop_front(); m_hist.push_back(p); exp_q.push_back(p);
    end
    if (m_walk) for (int i = 0; i < FN; i++) if (walk_en[i] && m_hist.size() > 0) begin
      p = m_hist.pop_back(); m_fl.push_front(p);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end
    for (int i = 0; i < FN; i++) if (free_en[i]) m_fl.push_back(free_preg[i]);
    if (!m_walk) begin
      if (redirect) m_walk = 1;
    end else if (walk_done && !redirect) m_walk = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_idle(); m_reset();
    #1;
    n_chk++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", alloc_ready); end
    n_chk++; if (free_cnt !== FL_CNT_W'(FL_SIZE)) begin n_fail++; $display("FAIL reset_cnt got %0d want %0d", free_cnt, FL_SIZE); end
    n_chk++; if (dbg_state !== FL_NORMAL) begin n_fail++; $display("FAIL reset_state got %0d want NORMAL", dbg_state); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_chk++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b want 1", alloc_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_drain();
    do_reset();
    alloc_en = '1;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk); m_expect();
      n_chk++; if (alloc_ready !== exp_ready) begin n_fail++; $display("FAIL drain_ready c=%0d got %b want %b", c, alloc_ready, exp_ready); end
      n_chk++; if (free_cnt !== exp_cnt) begin n_fail++; $display("FAIL drain_cnt c=%0d got %0d want %0d", c, free_cnt, exp_cnt); end
      n_chk++; if ((alloc_preg & exp_mask) !== exp_preg) begin n_fail++; $display("FAIL drain_preg c=%0d got %h want %h", c, alloc_preg & exp_mask, exp_preg); end
      if (c == 0) e_vec = {7'd35, 7'd34, 7'd33, 7'd32};
      if (c == 1) e_vec = {7'd39, 7'd38, 7'd37, 7'd36};
      if (c < 2) begin
        n_chk++; if (alloc_preg !== e_vec) begin n_fail++; $display("FAIL drain_first c=%0d got %h want %h", c, alloc_preg, e_vec); end
      end
      if (c == 24) begin
        n_chk++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL drain_empty_ready got %b want 0", alloc_ready); end
      end
      m_commit();
    end
    set_idle();
  endtask

  task automatic test_sparse();
    do_reset();
    alloc_en = 4'b1010;
    @(negedge clk); m_expect();
    n_chk++; if (alloc_preg[1] !== 7'd32 || alloc_preg[3] !== 7'd33) begin
      n_fail++; $display("FAIL sparse_grant got %0d,%0d want 32,33", alloc_preg[1], alloc_preg[3]); end
    n_chk++; if (alloc_ready !== exp_ready) begin n_fail++; $display("FAIL sparse_ready got %b want %b", alloc_ready, exp_ready); end
    m_commit();
    alloc_en = '0;
    @(negedge clk); m_expect();
    n_chk++; if (free_cnt !== 8'd94) begin n_fail++; $display("FAIL sparse_cnt got %0d want 94", free_cnt); end
    n_chk++; if (free_cnt !== exp_cnt) begin n_fail++; $display("FAIL sparse_model_cnt got %0d want %0d", free_cnt, exp_cnt); end
    m_commit();
  endtask

  task automatic test_free_refill();
    do_reset();
    alloc_en = '1;
    repeat (23) begin @(negedge clk); m_expect(); m_commit(); end
    alloc_en = 4'b0011;
    @(negedge clk); m_expect(); m_commit();
    alloc_en = '1; free_en = 4'b0011; free_preg[0] = 7'd5; free_preg[1] = 7'd7;
    @(negedge clk); m_expect();
    n_chk++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL refill_hold_ready got %b want 0", alloc_ready); end
    n_chk++; if (free_cnt !== 8'd2) begin n_fail++; $display("FAIL refill_hold_cnt got %0d want 2", free_cnt); end
    m_commit();
    free_en = '0;
    @(negedge clk); m_expect();
    n_chk++; if (free_cnt !== 8'd4) begin n_fail++; $display("FAIL refill_cnt got %0d want 4", free_cnt); end
    n_chk++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL refill_ready got %b want 1", alloc_ready); end
    n_chk++; if (alloc_preg[2] !== 7'd5 || alloc_preg[3] !== 7'd7) begin
      n_fail++; $display("FAIL refill_order got %0d,%0d want 5,7", alloc_preg[2], alloc_preg[3]); end
    n_chk++; if ((alloc_preg & exp_mask) !== exp_preg) begin n_fail++; $display("FAIL refill_preg got %h want %h", alloc_preg, exp_preg); end
    m_commit();
    set_idle();
  endtask

  task automatic test_walk();
    do_reset();
    alloc_en = '1;
    repeat (2) begin @(negedge clk); m_expect(); m_commit(); end
    alloc_en = '0; redirect = 1'b1;
    @(negedge clk); m_expect();
    n_chk++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL walk_redirect_ready got %b want 0", alloc_ready); end
    m_commit();
    redirect = 1'b0; walk_en = '1;
    @(negedge clk); m_expect();
    n_chk++; if (dbg_state !== FL_WALK) begin n_fail++; $display("FAIL walk_state got %0d want WALK", dbg_state); end
    n_chk++; if (free_cnt !== exp_cnt) begin n_fail++; $display("FAIL walk_cnt1 got %0d want %0d", free_cnt, exp_cnt); end
    m_commit();
    walk_done = 1'b1;
    @(negedge clk); m_expect();
    n_chk++; if (free_cnt !== exp_cnt) begin n_fail++; $display("FAIL walk_cnt2 got %0d want %0d", free_cnt, exp_cnt); end
    m_commit();
    set_idle(); alloc_en = 4'b0001;
    @(negedge clk); m_expect();
    n_chk++; if (dbg_state !== FL_NORMAL) begin n_fail++; $display("FAIL walk_exit_state got %0d want NORMAL", dbg_state); end
    n_chk++; if (free_cnt !== 8'd96) begin n_fail++; $display("FAIL walk_exit_cnt got %0d want 96", free_cnt); end
    n_chk++; if (alloc_ready !== 1'b1 || alloc_preg[0] !== 7'd32) begin
      n_fail++; $display("FAIL walk_regrant got rdy=%b preg=%0d want rdy=1 preg=32", alloc_ready, alloc_preg[0]); end
    m_commit();
    set_idle();
  endtask

  task automatic test_wrap();
    do_reset();
    alloc_en = '1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); m_expect();
      n_chk++; if (alloc_ready !== exp_ready) begin n_fail++; $display("FAIL wrap_ready c=%0d got %b want %b", c, alloc_ready, exp_ready); end
      n_chk++; if ((alloc_preg & exp_mask) !== exp_preg) begin n_fail++; $display("FAIL wrap_preg c=%0d got %h want %h", c, alloc_preg & exp_mask, exp_preg); end
      if (c >= 1) begin
        n_chk++; if (free_cnt !== 8'd92) begin n_fail++; $display("FAIL wrap_cnt c=%0d got %0d want 92", c, free_cnt); end
      end
      m_commit();
      free_en = '1;
      for (int i = 0; i < FN; i++) free_preg[i] = exp_q.pop_front();
    end
    set_idle();
  endtask

  task automatic test_rst_mid_walk();
    do_reset();
    alloc_en = '1;
    repeat (2) begin @(negedge clk); m_expect(); m_commit(); end
    alloc_en = '0; redirect = 1'b1;
    @(negedge clk); m_expect(); m_commit();
    redirect = 1'b0; walk_en = '1;
    @(negedge clk); m_expect(); m_commit();
    #2 rst = 1'b1;
    #1;
    n_chk++; if (free_cnt !== 8'd96) begin n_fail++; $display("FAIL rstwalk_cnt got %0d want 96", free_cnt); end
    n_chk++; if (dbg_state !== FL_NORMAL) begin n_fail++; $display("FAIL rstwalk_state got %0d want NORMAL", dbg_state); end
    set_idle(); m_reset();
    @(posedge clk); #1; rst = 1'b0;
    alloc_en = '1;
    @(negedge clk); m_expect();
    n_chk++; if (alloc_preg[0] !== 7'd32 || alloc_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstwalk_grant got rdy=%b preg=%0d want rdy=1 preg=32", alloc_ready, alloc_preg[0]); end
    m_commit();
    set_idle();
  endtask

  task automatic test_random();
    int idx;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      alloc_en = AN'($urandom_range(0, (1 << AN) - 1));
      free_en = '0; free_preg = '0;
      for (int i = 0; i < FN; i++) if ($urandom_range(0, 1) == 1 && exp_q.size() > 0) begin
        idx = $urandom_range(0, exp_q.size() - 1);
        free_en[i] = 1'b1; free_preg[i] = exp_q[idx]; exp_q.delete(idx);
      end
      @(negedge clk); m_expect();
      n_chk++; if (alloc_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready c=%0d got %b want %b", c, alloc_ready, exp_ready); end
      n_chk++; if (free_cnt !== exp_cnt) begin n_fail++; $display("FAIL rand_cnt c=%0d got %0d want %0d", c, free_cnt, exp_cnt); end
      n_chk++; if ((alloc_preg & exp_mask) !== exp_preg) begin n_fail++; $display("FAIL rand_preg c=%0d got %h want %h", c, alloc_preg & exp_mask, exp_preg); end
      m_commit();
    end
    set_idle();
  endtask

`ifdef PREG_FREELIST_PERF_EN
  task automatic test_perf();
    do_reset();
    alloc_en = '1;
    repeat (30) begin @(negedge clk); m_expect(); m_commit(); end
    set_idle();
    @(negedge clk);
    n_chk++; if (perf_stall !== 32'(m_stall)) begin n_fail++; $display("FAIL perf_stall got %0d want %0d", perf_stall, m_stall); end
    n_chk++; if (perf_min !== FL_CNT_W'(m_min)) begin n_fail++; $display("FAIL perf_min got %0d want %0d", perf_min, m_min); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    test_reset();
    test_full_drain();
    test_sparse();
    test_free_refill();
    test_walk();
    test_wrap();
    test_rst_mid_walk();
    test_random();
`ifdef PREG_FREELIST_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
